// File: rtl/mini_bit_core.sv
// mini_bit_core: two-word-instruction accumulator core with a serial OUT port.
// Define MINI_BIT_TX_PARITY_EN to add an even-parity bit to each tx frame.
module mini_bit_core #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int BAUD_DIV = 16
) (
  input  logic          clk,
  input  logic          reg_clear,
  input  logic          run,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          tx,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc
);

`ifdef MINI_BIT_TX_PARITY_EN
  localparam int FW = DW + 3;
`else
  localparam int FW = DW + 2;
`endif
  localparam int BCW = $clog2(BAUD_DIV);
  localparam int FCW = $clog2(FW + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH_OP, FETCH_ARG, EXEC, MEM, TX, HALT
  } state_t;

  state_t state, state_n;

  logic [DW-1:0]  ram [2**AW];
  logic [DW-1:0]  rd_q;
  logic [AW-1:0]  raddr;
  logic [AW-1:0]  k_addr;
  logic [3:0]     op_q;
  logic [DW-1:0]  a_q, b_q, a_n, b_n;
  logic           c_q, lt_q, z_q;
  logic           c_n, lt_n, z_n;
  logic [AW-1:0]  pc_n;
  logic [DW:0]    sum;
  logic [FW-1:0]  sh_q, frame;
  logic [BCW-1:0] baud_q;
  logic [FCW-1:0] bit_q;
  logic           baud_end, last_bit;

  // In EXEC the read register holds the operand word k.
  assign k_addr   = AW'(rd_q);
  assign baud_end = baud_q == BCW'(BAUD_DIV - 1);
  assign last_bit = baud_end && bit_q == FCW'(FW - 1);

`ifdef MINI_BIT_TX_PARITY_EN
  assign frame = {1'b1, ^a_q, a_q, 1'b0};
`else
  assign frame = {1'b1, a_q, 1'b0};
`endif

  assign tx     = (state == TX) ? sh_q[0] : 1'b1;
  assign halted = state == HALT;
  assign acc    = a_q;

  always_comb begin
    raddr = pc;
    unique case (1'b1)
      state == FETCH_ARG: raddr = pc + AW'(1);
      state == EXEC:      raddr = k_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == EXEC && op_q == 4'h4)
      ram[k_addr] <= a_q;
    else if (ld_we && (state == IDLE || state == HALT))
      ram[ld_addr] <= ld_data;
    rd_q <= ram[raddr];
  end

  always_comb begin
    a_n  = a_q;
    b_n  = b_q;
    c_n  = c_q;
    lt_n = lt_q;
    z_n  = z_q;
    pc_n = pc + AW'(2);
    sum  = {1'b0, a_q} + {1'b0, b_q}
         + {{DW{1'b0}}, (op_q == 4'h6) & c_q};
    case (op_q)
      4'h1: a_n = rd_q;
      4'h2: b_n = rd_q;
      4'h5, 4'h6: {c_n, a_n} = sum;
      4'h7: begin
        a_n = ~(a_q & b_q);
        c_n = 1'b0;
      end
      4'h8: begin
        a_n = {a_q[DW-2:0], 1'b0};
        c_n = a_q[DW-1];
      end
      4'h9: begin
        a_n = {1'b0, a_q[DW-1:1]};
        c_n = a_q[0];
      end
      4'hA: pc_n = k_addr;
      4'hB: if (lt_q) pc_n = k_addr;
      4'hC: if (z_q) pc_n = k_addr;
      default: ;
    endcase
    if (op_q >= 4'h5 && op_q <= 4'h9) begin
      lt_n = a_q < b_q;
      z_n  = a_n == '0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (run) state_n = FETCH_OP;
      FETCH_OP:  state_n = FETCH_ARG;
      FETCH_ARG: state_n = EXEC;
      EXEC: begin
        case (op_q)
          4'h3, 4'h4: state_n = MEM;
          4'hD:       state_n = TX;
          4'hE:       state_n = HALT;
          default:    state_n = run ? FETCH_OP : IDLE;
        endcase
      end
      MEM:  state_n = run ? FETCH_OP : IDLE;
      TX:   if (last_bit) state_n = run ? FETCH_OP : IDLE;
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reg_clear) begin
    if (reg_clear) begin
      state  <= IDLE;
      pc     <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      lt_q   <= 1'b0;
      z_q    <= 1'b0;
      sh_q   <= '1;
      baud_q <= '0;
      bit_q  <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH_ARG)
        op_q <= rd_q[3:0];
      if (state == EXEC) begin
        pc   <= pc_n;
        a_q  <= a_n;
        b_q  <= b_n;
        c_q  <= c_n;
        lt_q <= lt_n;
        z_q  <= z_n;
      end
      if (state == MEM && op_q == 4'h3)
        a_q <= rd_q;
      // Frame is latched from A at OUT's EXEC and shifted LSB first.
      if (state == EXEC && op_q == 4'hD) begin
        sh_q   <= frame;
        baud_q <= '0;
        bit_q  <= '0;
      end else if (state == TX) begin
        if (baud_end) begin
          baud_q <= '0;
          bit_q  <= bit_q + FCW'(1);
          sh_q   <= {1'b1, sh_q[FW-1:1]};
        end else begin
          baud_q <= baud_q + BCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mini_bit_core.sv
// Directed scoreboard bench for mini_bit_core (DW=8, AW=8, BAUD_DIV=16).
// Expected acc values and tx frames are queued at load time, popped at checks.
module tb_mini_bit_core;

  logic       clk = 1'b0;
  logic       reg_clear = 1'b1;
  logic       run = 1'b0;
  logic       ld_we = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       tx, halted;
  logic [7:0] pc, acc;

  int n_chk = 0;
  int n_pass = 0;
  int n;

  logic [7:0] exp_acc[$];
  logic [7:0] exp_frm[$];

  always #5 clk = ~clk;

  mini_bit_core #(.DW(8), .AW(8), .BAUD_DIV(16)) dut (
    .clk(clk),
    .reg_clear(reg_clear),
    .run(run),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .tx(tx),
    .halted(halted),
    .pc(pc),
    .acc(acc)
  );

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_acc(input string tag);
    logic [7:0] e;
    e = 8'h00;
    if (exp_acc.size() > 0) e = exp_acc.pop_front();
    check(tag, {24'h0, acc}, {24'h0, e});
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_we = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick(1);
    ld_we = 1'b0;
  endtask

  task automatic do_reset();
    run = 1'b0;
    reg_clear = 1'b1;
    tick(2);
    reg_clear = 1'b0;
    tick(1);
  endtask

  task automatic wait_pc(input string tag, input logic [7:0] target,
                         input int budget, output int cnt);
    cnt = 0;
    while (pc !== target && cnt < budget) begin
      tick(1);
      cnt++;
    end
    check(tag, {24'h0, pc}, {24'h0, target});
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int c;
    c = 0;
    while (halted !== 1'b1 && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, {31'h0, halted}, 32'h1);
  endtask

  task automatic get_frame(input string tag);
    int c;
    logic [7:0] d, e;
    c = 0;
    d = '0;
    while (tx !== 1'b0 && c < 400) begin
      tick(1);
      c++;
    end
    check({tag, "_start"}, {31'h0, tx}, 32'h0);
    tick(15);
    check({tag, "_start_len"}, {31'h0, tx}, 32'h0);
    tick(9);
    for (int b = 0; b < 8; b++) begin
      d[b] = tx;
      if (b < 7) tick(16);
    end
    e = 8'h00;
    if (exp_frm.size() > 0) e = exp_frm.pop_front();
`ifdef MINI_BIT_TX_PARITY_EN
    tick(16);
    check({tag, "_parity"}, {31'h0, tx}, {31'h0, ^e});
`endif
    tick(16);
    check({tag, "_stop"}, {31'h0, tx}, 32'h1);
    check({tag, "_data"}, {24'h0, d}, {24'h0, e});
  endtask

  initial begin
    tick(2);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_pc", {24'h0, pc}, 32'h0);
    check("rst_acc", {24'h0, acc}, 32'h0);
    reg_clear = 1'b0;
    tick(1);

    // Program A: LDA 5; LDB 3; ADD; OUT; HALT
    load(0, 8'h01); load(1, 8'h05); load(2, 8'h02); load(3, 8'h03);
    load(4, 8'h05); load(5, 8'h00); load(6, 8'h0D); load(7, 8'h00);
    load(8, 8'h0E); load(9, 8'h00);
    exp_acc.push_back(8'h05);
    exp_acc.push_back(8'h08);
    exp_frm.push_back(8'h08);
    run = 1'b1;
    tick(9);
    check_acc("a_add_pending");
    tick(1);
    check_acc("a_add_retired");
    check("a_pc_after_add", {24'h0, pc}, 32'h6);
    get_frame("a_frame");
    wait_halt("a_halted", 100);
    check("a_pc_halt", {24'h0, pc}, 32'ha);

    // Program B: arithmetic, flags, branches, STA/LDM, OUT 0x81
    do_reset();
    load(0, 8'h01);  load(1, 8'hFF);
    load(2, 8'h02);  load(3, 8'h01);
    load(4, 8'h05);  load(5, 8'h00);
    load(6, 8'h0C);  load(7, 8'h0A);
    load(8, 8'h0E);  load(9, 8'h00);
    load(10, 8'h06); load(11, 8'h00);
    load(12, 8'h0B); load(13, 8'h10);
    load(14, 8'h0E); load(15, 8'h00);
    load(16, 8'h01); load(17, 8'h5A);
    load(18, 8'h04); load(19, 8'h40);
    load(20, 8'h03); load(21, 8'h40);
    load(22, 8'h08); load(23, 8'h00);
    load(24, 8'h09); load(25, 8'h00);
    load(26, 8'h01); load(27, 8'h81);
    load(28, 8'h0D); load(29, 8'h00);
    load(30, 8'h08); load(31, 8'h00);
    load(32, 8'h06); load(33, 8'h00);
    load(34, 8'h07); load(35, 8'h00);
    load(36, 8'h0E); load(37, 8'h00);
    load(8'h40, 8'h11);
    exp_acc.push_back(8'h00);
    exp_acc.push_back(8'h00);
    exp_acc.push_back(8'h02);
    exp_acc.push_back(8'h5A);
    exp_acc.push_back(8'h5A);
    exp_acc.push_back(8'hB4);
    exp_acc.push_back(8'h5A);
    exp_acc.push_back(8'h81);
    exp_acc.push_back(8'h02);
    exp_acc.push_back(8'h04);
    exp_acc.push_back(8'hFF);
    exp_frm.push_back(8'h81);
    run = 1'b1;
    tick(1);
    ld_we = 1'b1;
    ld_addr = 8'd34;
    ld_data = 8'h01;
    tick(3);
    ld_we = 1'b0;
    wait_pc("b_pc6", 8'd6, 60, n);    check_acc("b_add_wrap");
    wait_pc("b_pc10", 8'd10, 60, n);  check_acc("b_jz_taken");
    wait_pc("b_pc12", 8'd12, 60, n);  check_acc("b_adc_carry");
    wait_pc("b_pc18", 8'd18, 60, n);  check_acc("b_lda5a");
    wait_pc("b_pc22", 8'd22, 60, n);  check_acc("b_ldm_new");
    wait_pc("b_pc24", 8'd24, 60, n);  check_acc("b_shl");
    check("b_ldm_cycles", n, 4);
    wait_pc("b_pc26", 8'd26, 60, n);  check_acc("b_shr");
    check("b_shr_cycles", n, 3);
    wait_pc("b_pc28", 8'd28, 60, n);  check_acc("b_lda81");
    get_frame("b_frame");
    wait_pc("b_pc32", 8'd32, 60, n);  check_acc("b_shl_c");
    wait_pc("b_pc34", 8'd34, 60, n);  check_acc("b_adc_c1");
    wait_pc("b_pc36", 8'd36, 60, n);  check_acc("b_nand_ldwe");
    wait_halt("b_halted", 60);
    check("b_pc_halt", {24'h0, pc}, 32'd38);

    // Odd pc wrap: operand of the instruction at 0xFF comes from 0x00
    do_reset();
    load(0, 8'h1A); load(1, 8'hFF); load(2, 8'h00);
    load(3, 8'h0E); load(4, 8'h00); load(8'hFF, 8'h01);
    exp_acc.push_back(8'h1A);
    run = 1'b1;
    wait_pc("w_pcff", 8'hFF, 20, n);
    wait_pc("w_pc01", 8'h01, 20, n);
    check_acc("w_operand_wrap");
    wait_halt("w_halted", 40);
    check("w_pc_halt", {24'h0, pc}, 32'h5);

    // Even pc wrap: NOP at 0xFE then JMP at 0xFE with k=0
    do_reset();
    load(0, 8'h0A); load(1, 8'hFE); load(8'hFE, 8'h0F); load(8'hFF, 8'h00);
    run = 1'b1;
    wait_pc("e_pcfe", 8'hFE, 20, n);
    wait_pc("e_nop_wrap", 8'h00, 20, n);
    check("e_nop_cycles", n, 3);
    run = 1'b0;
    tick(10);
    check("e_pc_kept", {24'h0, pc}, 32'hFE);
    load(8'hFE, 8'h0A);
    run = 1'b1;
    wait_pc("e_jmp_wrap", 8'h00, 20, n);
    check("e_jmp_cycles", n, 4);
    run = 1'b0;
    tick(10);

    // Reset in the middle of a frame
    do_reset();
    load(0, 8'h01); load(1, 8'hC3); load(2, 8'h0D);
    load(3, 8'h00); load(4, 8'h0E); load(5, 8'h00);
    run = 1'b1;
    n = 0;
    while (tx !== 1'b0 && n < 60) begin
      tick(1);
      n++;
    end
    check("r_frame_began", {31'h0, tx}, 32'h0);
    tick(20);
    #2;
    reg_clear = 1'b1;
    #1;
    check("r_tx_async", {31'h0, tx}, 32'h1);
    check("r_pc_async", {24'h0, pc}, 32'h0);
    check("r_halted_async", {31'h0, halted}, 32'h0);
    run = 1'b0;
    tick(2);
    reg_clear = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (tx !== 1'b1) n++;
    end
    check("r_no_resume", n, 0);
    exp_frm.push_back(8'hC3);
    run = 1'b1;
    get_frame("r_ram_kept");
    wait_halt("r_halted", 60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mini_bit_core.md
MINI_BIT_CORE -- requirements
Module: mini_bit_core

Interface
REQ-001 Parameter DW, default 8: data/bus width; SHALL be >= 8.
REQ-002 Parameter AW, default 8: RAM address width; RAM depth SHALL be 2**AW words of DW bits.
REQ-003 Parameter BAUD_DIV, default 16: clk cycles per serial bit; SHALL be >= 2.
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-005 reg_clear  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  level; high SHALL permit instruction execution.
REQ-007 ld_we  input  1  program-load write strobe.
REQ-008 ld_addr  input  AW  program-load address.
REQ-009 ld_data  input  DW  program-load data.
REQ-010 tx  output  1  serial output; idle high.
REQ-011 halted  output  1  high while in HALT state.
REQ-012 pc  output  AW  current instruction pointer.
REQ-013 acc  output  DW  register A contents.

Function
REQ-014 Instruction SHALL be two words: opcode word (op = bits [3:0], upper bits ignored) at pc, operand word k at pc+1.
REQ-015 Opcodes: 0 NOP; 1 LDA A=k; 2 LDB B=k; 3 LDM A=RAM[k]; 4 STA RAM[k]=A; 5 ADD A=A+B; 6 ADC A=A+B+C; 7 NAND A=~(A&B); 8 SHL A=A<<1; 9 SHR A=A>>1; A JMP; B JLT; C JZ; D OUT; E HALT; F NOP.
REQ-016 FSM states IDLE, FETCH_OP, FETCH_ARG, EXEC, MEM, TX, HALT; reset state IDLE.
REQ-017 IDLE->FETCH_OP when run=1; FETCH_OP->FETCH_ARG->EXEC one cycle each; non-memory, non-OUT instruction SHALL take exactly 3 cycles.
REQ-018 LDM and STA SHALL pass EXEC->MEM, adding one cycle (4 total).
REQ-019 OUT SHALL go EXEC->TX and stay until frame stop bit completes, then continue.
REQ-020 After EXEC/MEM/TX: next state FETCH_OP if run=1, else IDLE with pc preserved; run low SHALL never abort an instruction in progress.
REQ-021 pc SHALL advance by 2 per instruction, modulo 2**AW (wrap 2**AW-1 -> 1 and 2**AW-2 -> 0); operand fetch at pc+1 SHALL also wrap.
REQ-022 JMP pc=k; JLT pc=k if LT=1; JZ pc=k if Z=1; otherwise pc+2.
REQ-023 Flags C, LT, Z SHALL update only on opcodes 5-9; other opcodes SHALL leave them unchanged.
REQ-024 ADD/ADC: C = carry out of bit DW-1; NAND: C=0; SHL: C=old A[DW-1]; SHR: C=old A[0], zero shifted in.
REQ-025 LT = (old A < B) unsigned; Z = (new A == 0); all within the same EXEC cycle.
REQ-026 HALT state SHALL be left only by reg_clear; halted=1 from the cycle after HALT's EXEC.
REQ-027 ld_we SHALL write RAM only in IDLE or HALT; ignored otherwise.
REQ-028 Serial frame: start 0, DW data bits LSB first, stop 1, each bit BAUD_DIV cycles; frame data = A at EXEC.
REQ-029 RAM read latency one cycle; STA write and LDM read to same address in consecutive instructions SHALL return the new value.

Reset
REQ-030 On reg_clear: state IDLE, pc=0, A=B=0, C=LT=Z=0, tx=1, halted=0, baud/bit counters 0; RAM contents SHALL be unchanged.
REQ-031 Reset mid-frame SHALL force tx=1 immediately; no partial frame resumes.

Configuration
REQ-032 Macro MINI_BIT_TX_PARITY_EN defined: an even-parity bit (XOR of data) SHALL be sent between last data bit and stop bit, frame DW+3 bits.
REQ-033 Macro undefined: no parity bit; frame DW+2 bits.

Verification
REQ-034 Load {1,5,2,3,5,0,D,0,E,0} at 0, run=1 -> tx frame data 0x08, then halted=1; ADD retired 3 cycles after issue.
REQ-035 A=0xFF, B=0x01, ADD -> A=0x00, C=1, Z=1, LT=0; following ADC with B=0x01 -> A=0x02, C=0.
REQ-036 STA 0x40 then LDM 0x40 with A=0x5A -> acc=0x5A; LDM completes in 4 cycles.
REQ-037 JMP at 0xFE with AW=8, k=0x00 -> pc=0x00; NOP at 0xFE -> pc wraps to 0x00.
REQ-038 OUT with BAUD_DIV=16, A=0x81 -> start bit low 16 cycles, bits 1,0,0,0,0,0,0,1, stop high; with MINI_BIT_TX_PARITY_EN parity bit=0 before stop.
REQ-039 reg_clear asserted mid-OUT frame -> tx=1, pc=0, halted=0 asynchronously; ld_we during run ignored.
